fetch_unit: RTL

- Instruction fetch stage, producer side of the fetch→decode handshake.
- Maintains the program counter and issues one-outstanding requests to instruction memory.
- Captures each returned word and presents it with its PC to decode using a valid/ready transfer.
- Accepts a redirect (branch/jump target) from later stages and squashes any in-flight or presented instruction.

---
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage: owns the program counter, issues one request at a
// time to instruction memory, captures the returned word and hands it to
// decode over a valid/ready transfer. A redirect from a later stage retargets
// the PC and squashes whatever is in flight or being presented.
//
// Ports
//   clk             pipeline clock, rising edge
//   rst_n           synchronous active-low reset
//   imem_req        request valid to instruction memory (registered)
//   imem_addr       word-aligned fetch address (registered)
//   imem_gnt        memory accepts the request this cycle
//   imem_rvalid     read data valid, one per issued request
//   imem_rdata      returned instruction word
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch target (low two bits ignored)
//   instruction     instruction presented to decode (registered)
//   pc              address of the presented instruction (registered)
//   valid           instruction/pc valid (registered)
//   ready           decode accepts; transfer = valid && ready
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  valid,
  input  logic                  ready
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e                state_q,    state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  drop_q,     drop_d;
  logic                  imem_req_q, imem_req_d;
  logic [DATA_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0] instr_q,    instr_d;
  logic [DATA_WIDTH-1:0] pc_q,       pc_d;
  logic                  valid_q,    valid_d;

  logic                  issue;
  logic                  stale_pending;
  logic [DATA_WIDTH-1:0] redirect_target;

  // Fetch addresses are word aligned; masking keeps every input bit in use.
  assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);

  // A request is only on the bus when the registered req is high, so the
  // first FETCH cycle after reset (req still 0) cannot issue.
  assign issue = imem_req_q && imem_gnt;

  // A response is still owed by memory if we were waiting, already dropping,
  // or issuing right now -- unless it is arriving this very cycle.
  assign stale_pending = (drop_q || (state_q == WAIT) || issue) && !imem_rvalid;

  // NOTE: every variable driven here gets a default first so that no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      FETCH: begin
        // A late response to a request cut off by reset retires the drop.
        if (drop_q && imem_rvalid) begin
          drop_d = 1'b0;
        end
        if (issue) begin
          state_d = WAIT;
          // The request just issued targets the old PC: mark its data stale.
          if (redirect_valid) begin
            drop_d = 1'b1;
          end
        end
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            instr_d    = imem_rdata;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
            state_d    = OUT;
          end
          if (redirect_valid) begin
            fetch_pc_d = redirect_target;
          end
        end else if (redirect_valid) begin
          drop_d     = 1'b1;
          fetch_pc_d = redirect_target;
        end
      end

      OUT: begin
        // A transfer coinciding with a redirect still completes; decode is
        // responsible for squashing that instruction.
        if (ready || redirect_valid) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Memory outputs are registered from next state, so they line up with
    // the state they belong to. Fetch is held off while a stale response is
    // still owed, keeping at most one request outstanding.
    imem_req_d  = (state_d == FETCH) && !drop_d;
    imem_addr_d = fetch_pc_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      drop_q      <= stale_pending;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      instr_q     <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_q      <= drop_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign valid       = valid_q;

  // Read data is only expected while waiting, or as the retiring response of
  // a request that reset cut off.
  a_rvalid_when_waiting: assert property (
    @(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> ((state_q == WAIT) || drop_q)
  );

  // A presented instruction is only withdrawn by transfer, redirect or reset.
  a_valid_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
      (valid_q && !ready && !redirect_valid) |=> valid_q
  );

endmodule
